// File: rtl/request_unit_llsc_if.sv
// Bus between the control unit side and the data request unit: request
// qualifiers and snoop traffic in, memory strobes and LL/SC status out.
interface request_unit_llsc_if #(
    parameter int ADDR_W = 32
);
    logic              ihit;
    logic              dhit;
    logic              cu_dren;
    logic              cu_dwen;
    logic              cu_ll;
    logic              cu_sc;
    logic [ADDR_W-1:0] daddr;
    logic              snoop_inv;
    logic [ADDR_W-1:0] snoop_addr;
    logic              dREN;
    logic              dWEN;
    logic              sc_valid;
    logic              sc_result;
    logic              link_valid;
    logic              req_timeout;

    // Pipeline/cache side that drives requests and observes the strobes.
    modport master (
        output ihit, dhit, cu_dren, cu_dwen, cu_ll, cu_sc, daddr,
               snoop_inv, snoop_addr,
        input  dREN, dWEN, sc_valid, sc_result, link_valid, req_timeout
    );

    // The request unit itself.
    modport slave (
        input  ihit, dhit, cu_dren, cu_dwen, cu_ll, cu_sc, daddr,
               snoop_inv, snoop_addr,
        output dREN, dWEN, sc_valid, sc_result, link_valid, req_timeout
    );
endinterface

// File: rtl/request_unit_llsc.sv
// Data request unit with load-linked / store-conditional link tracking,
// snoop invalidation of the link and a sticky watchdog on pending requests.
module request_unit_llsc #(
    parameter int ADDR_W   = 32,
    parameter int LINK_LSB = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                CLK,
    input  logic                RST,
    request_unit_llsc_if.slave  bus
);

    localparam int TAG_W = ADDR_W - LINK_LSB;
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        SC_FAIL = 2'd2
    } state_t;

    state_t             state, state_next;
    logic               ren, ren_next;
    logic               wen, wen_next;
    logic               scv, scv_next;
    logic               scr, scr_next;
    logic               link_v, link_v_next;
    logic [TAG_W-1:0]   link_tag, link_tag_next;
    logic [TAG_W-1:0]   req_tag, req_tag_next;
    logic               req_ll, req_ll_next;
    logic               req_sc, req_sc_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               tout, tout_next;

    // Only the bits above LINK_LSB take part in link compares, so only
    // those are stored for the link and the captured request.
    logic [TAG_W-1:0]   d_tag;
    logic [TAG_W-1:0]   s_tag;
    logic               issue;

    assign d_tag = bus.daddr[ADDR_W-1:LINK_LSB];
    assign s_tag = bus.snoop_addr[ADDR_W-1:LINK_LSB];
    assign issue = bus.ihit && (bus.cu_dren || bus.cu_dwen);

    if (LINK_LSB > 0) begin : g_low_bits
        logic unused_low_bits;
        assign unused_low_bits = ^{bus.daddr[LINK_LSB-1:0], bus.snoop_addr[LINK_LSB-1:0]};
    end

    // State and output registers; everything visible outside is registered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values computed by the comb block.
            state    <= IDLE;
            ren      <= 1'b0;
            wen      <= 1'b0;
            scv      <= 1'b0;
            scr      <= 1'b0;
            link_v   <= 1'b0;
            link_tag <= '0;
            req_tag  <= '0;
            req_ll   <= 1'b0;
            req_sc   <= 1'b0;
            cnt      <= '0;
            tout     <= 1'b0;
        end else begin
            state    <= state_next;
            ren      <= ren_next;
            wen      <= wen_next;
            scv      <= scv_next;
            scr      <= scr_next;
            link_v   <= link_v_next;
            link_tag <= link_tag_next;
            req_tag  <= req_tag_next;
            req_ll   <= req_ll_next;
            req_sc   <= req_sc_next;
            cnt      <= cnt_next;
            tout     <= tout_next;
        end
    end

    // Next-state, request strobes, LL/SC link bookkeeping and watchdog.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_next    = state;
        ren_next      = ren;
        wen_next      = wen;
        scv_next      = 1'b0;
        scr_next      = 1'b0;
        link_v_next   = link_v;
        link_tag_next = link_tag;
        req_tag_next  = req_tag;
        req_ll_next   = req_ll;
        req_sc_next   = req_sc;
        cnt_next      = cnt;
        tout_next     = tout;

        case (state)
            IDLE: begin
                if (issue) begin
                    req_tag_next = d_tag;
                    req_ll_next  = bus.cu_ll && !bus.cu_dwen;
                    req_sc_next  = bus.cu_sc && bus.cu_dwen;
                    if (!bus.cu_dwen) begin
                        ren_next   = 1'b1;
                        cnt_next   = '0;
                        state_next = PEND;
                    end else if (!bus.cu_sc || (link_v && link_tag == d_tag)) begin
                        // SC success is decided here; later snoops cannot undo it.
                        wen_next   = 1'b1;
                        cnt_next   = '0;
                        state_next = PEND;
                    end else begin
                        scv_next   = 1'b1;
                        scr_next   = 1'b0;
                        state_next = SC_FAIL;
                    end
                end
            end

            PEND: begin
                if (cnt != CNT_MAX) begin
                    cnt_next = cnt + 1'b1;
                end
                // The flag trips on the edge the count reaches TIMEOUT, even if
                // dhit arrives in that same last pending cycle.
                if (cnt_next == CNT_MAX) begin
                    tout_next = 1'b1;
                end
                if (bus.dhit) begin
                    ren_next   = 1'b0;
                    wen_next   = 1'b0;
                    state_next = IDLE;
                    if (req_ll) begin
                        link_v_next   = 1'b1;
                        link_tag_next = req_tag;
                    end
                    if (req_sc) begin
                        scv_next    = 1'b1;
                        scr_next    = 1'b1;
                        link_v_next = 1'b0;
                    end else if (wen && link_tag == req_tag) begin
                        link_v_next = 1'b0;
                    end
                end
            end

            SC_FAIL: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Snoop compares against the link as it would stand after this
        // cycle, so an invalidate racing an LL completion kills the new link.
        if (bus.snoop_inv && link_tag_next == s_tag) begin
            link_v_next = 1'b0;
        end
    end

    assign bus.dREN        = ren;
    assign bus.dWEN        = wen;
    assign bus.sc_valid    = scv;
    assign bus.sc_result   = scr;
    assign bus.link_valid  = link_v;
    assign bus.req_timeout = tout;

endmodule

// File: tb/tb_request_unit_llsc.sv
// Self-checking bench for request_unit_llsc: directed LL/SC, snoop, race,
// watchdog and reset scenarios followed by randomized transactions scored
// against a transaction-level model of the link and watchdog.
module tb_request_unit_llsc;

    localparam int ADDR_W   = 32;
    localparam int LINK_LSB = 2;
    localparam int TIMEOUT  = 4;

    logic clk;
    logic rst;

    int checks;
    int failures;

    // Transaction-level reference state.
    bit          m_link_v;
    logic [31:0] m_link_tag;
    bit          m_timeout;

    request_unit_llsc_if #(.ADDR_W(ADDR_W)) bus ();

    request_unit_llsc #(
        .ADDR_W   (ADDR_W),
        .LINK_LSB (LINK_LSB),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> LINK_LSB;
    endfunction

    task automatic clear_inputs();
        bus.ihit       = 1'b0;
        bus.dhit       = 1'b0;
        bus.cu_dren    = 1'b0;
        bus.cu_dwen    = 1'b0;
        bus.cu_ll      = 1'b0;
        bus.cu_sc      = 1'b0;
        bus.snoop_inv  = 1'b0;
    endtask

    // kind: 0 load, 1 LL, 2 store, 3 SC. delay = pending cycles (dhit in the last).
    // snoop_cyc: pending cycle carrying snoop_inv to saddr, 0 for none.
    task automatic do_req(input int kind, input logic [31:0] addr, input int delay,
                          input int snoop_cyc, input logic [31:0] saddr);
        bit is_store;
        bit sc_ok;
        is_store = (kind >= 2);
        sc_ok    = m_link_v && (tag_of(addr) == m_link_tag);

        bus.ihit    = 1'b1;
        bus.cu_dren = !is_store;
        bus.cu_dwen = is_store;
        bus.cu_ll   = (kind == 1);
        bus.cu_sc   = (kind == 3);
        bus.daddr   = addr;
        tick();
        clear_inputs();

        if (kind == 3 && !sc_ok) begin
            check("scfail_dren", bus.dREN, 0);
            check("scfail_dwen", bus.dWEN, 0);
            check("scfail_valid", bus.sc_valid, 1);
            check("scfail_result", bus.sc_result, 0);
            tick();
            check("scfail_pulse_end", bus.sc_valid, 0);
            check("scfail_no_dwen", bus.dWEN, 0);
            return;
        end

        for (int i = 1; i <= delay; i++) begin
            check("pend_dren", bus.dREN, !is_store);
            check("pend_dwen", bus.dWEN, is_store);
            check("pend_sc_valid", bus.sc_valid, 0);
            check("pend_timeout", bus.req_timeout, m_timeout || (i > TIMEOUT));
            // Junk on the control inputs must not disturb a pending request.
            bus.ihit       = 1'($urandom);
            bus.cu_dren    = 1'($urandom);
            bus.cu_dwen    = 1'($urandom);
            bus.cu_ll      = 1'($urandom);
            bus.cu_sc      = 1'($urandom);
            bus.daddr      = $urandom;
            bus.dhit       = (i == delay);
            bus.snoop_inv  = (i == snoop_cyc);
            bus.snoop_addr = saddr;
            if (i == snoop_cyc && i != delay && m_link_v && tag_of(saddr) == m_link_tag)
                m_link_v = 1'b0;
            tick();
        end
        clear_inputs();

        if (kind == 1) begin
            m_link_v   = 1'b1;
            m_link_tag = tag_of(addr);
        end
        if (kind == 3) m_link_v = 1'b0;
        if (kind == 2 && m_link_v && tag_of(addr) == m_link_tag) m_link_v = 1'b0;
        if (snoop_cyc == delay && m_link_v && tag_of(saddr) == m_link_tag) m_link_v = 1'b0;
        if (delay >= TIMEOUT) m_timeout = 1'b1;

        check("done_dren", bus.dREN, 0);
        check("done_dwen", bus.dWEN, 0);
        check("done_sc_valid", bus.sc_valid, kind == 3);
        check("done_sc_result", bus.sc_result, kind == 3);
        check("done_link_valid", bus.link_valid, m_link_v);
        check("done_timeout", bus.req_timeout, m_timeout);
    endtask

    task automatic snoop_idle(input logic [31:0] saddr);
        bus.snoop_inv  = 1'b1;
        bus.snoop_addr = saddr;
        tick();
        bus.snoop_inv  = 1'b0;
        if (m_link_v && tag_of(saddr) == m_link_tag) m_link_v = 1'b0;
        check("snoop_link_valid", bus.link_valid, m_link_v);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        m_link_v   = 1'b0;
        m_link_tag = '0;
        m_timeout  = 1'b0;
        clear_inputs();
        bus.daddr      = '0;
        bus.snoop_addr = '0;

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        check("rst_dren", bus.dREN, 0);
        check("rst_dwen", bus.dWEN, 0);
        check("rst_sc_valid", bus.sc_valid, 0);
        check("rst_sc_result", bus.sc_result, 0);
        check("rst_link_valid", bus.link_valid, 0);
        check("rst_timeout", bus.req_timeout, 0);
        rst = 1'b0;
        tick();

        // dhit while idle is ignored.
        bus.dhit = 1'b1;
        tick();
        bus.dhit = 1'b0;
        check("idle_dhit_dren", bus.dREN, 0);
        check("idle_dhit_dwen", bus.dWEN, 0);

        // Plain load held for exactly three cycles.
        do_req(0, 32'h080, 3, 0, 0);

        // LL then SC to a different word fails, SC to the linked word succeeds.
        do_req(1, 32'h100, 2, 0, 0);
        check("ll_link_valid", bus.link_valid, 1);
        do_req(3, 32'h104, 1, 0, 0);
        do_req(3, 32'h100, 2, 0, 0);
        check("sc_ok_link_cleared", bus.link_valid, 0);

        // Snoop to another byte of the linked word kills the link.
        do_req(1, 32'h200, 1, 0, 0);
        snoop_idle(32'h203);
        do_req(3, 32'h200, 1, 0, 0);

        // Snoop racing the LL completion wins; snoop to other word does not.
        do_req(1, 32'h300, 2, 2, 32'h300);
        check("race_link_valid", bus.link_valid, 0);
        do_req(1, 32'h300, 2, 1, 32'h304);
        check("race_other_link_valid", bus.link_valid, 1);

        // Snoop while an SC is pending does not change its outcome.
        do_req(3, 32'h300, 3, 1, 32'h300);

        // Plain store to the linked word clears the link; other words do not.
        do_req(1, 32'h400, 1, 0, 0);
        do_req(2, 32'h408, 2, 0, 0);
        do_req(2, 32'h402, 2, 0, 0);

        // Randomized transactions over a small address pool to force matches.
        for (int n = 0; n < 60; n++) begin
            int          kind;
            int          delay;
            int          scyc;
            logic [31:0] a;
            logic [31:0] s;
            kind  = $urandom_range(0, 3);
            delay = $urandom_range(1, TIMEOUT - 1);
            a     = 32'h500 + (32'($urandom_range(0, 2)) << 2) + 32'($urandom_range(0, 3));
            s     = 32'h500 + (32'($urandom_range(0, 2)) << 2) + 32'($urandom_range(0, 3));
            scyc  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, delay) : 0;
            do_req(kind, a, delay, scyc, s);
            if ($urandom_range(0, 4) == 0) snoop_idle(s);
        end

        // Watchdog: a store left pending ten cycles trips the sticky flag.
        do_req(2, 32'h600, 10, 0, 0);
        check("wd_sticky", bus.req_timeout, 1);
        tick();
        check("wd_sticky_later", bus.req_timeout, 1);

        // Asynchronous reset in the middle of a pending store with a live link.
        do_req(1, 32'h700, 1, 0, 0);
        bus.ihit    = 1'b1;
        bus.cu_dwen = 1'b1;
        bus.daddr   = 32'h800;
        tick();
        clear_inputs();
        check("pre_rst_dwen", bus.dWEN, 1);
        check("pre_rst_link", bus.link_valid, 1);
        tick();
        rst = 1'b1;
        #1;
        check("async_rst_dren", bus.dREN, 0);
        check("async_rst_dwen", bus.dWEN, 0);
        check("async_rst_sc_valid", bus.sc_valid, 0);
        check("async_rst_link", bus.link_valid, 0);
        check("async_rst_timeout", bus.req_timeout, 0);
        tick();
        rst        = 1'b0;
        m_link_v   = 1'b0;
        m_timeout  = 1'b0;
        tick();
        do_req(0, 32'h900, 2, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL timeout_guard observed=running expected=finished");
        $fatal(1, "simulation time bound exceeded");
    end

endmodule

// File: doc/request_unit_llsc.md
Name: request_unit_llsc

Overview:
Parametrised successor to the pipeline's data request unit. It sits between the control unit and the memory/cache interface. It raises and holds dREN/dWEN for a memory-stage access until dhit, and adds load-linked/store-conditional (LL/SC) link tracking with snoop invalidation. It also adds a watchdog that flags requests left pending too long.

Parameters:
ADDR_W, 32, data address width
LINK_LSB, 2, low address bits ignored in link compares (2 = word granularity)
TIMEOUT, 255, pending cycles before req_timeout sets (must be >= 1)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
ihit  input  1  instruction fetch complete; pipeline advances this cycle
dhit  input  1  data access complete
cu_dren  input  1  memory-stage instruction is a load
cu_dwen  input  1  memory-stage instruction is a store
cu_ll  input  1  load is load-linked (valid with cu_dren)
cu_sc  input  1  store is store-conditional (valid with cu_dwen)
daddr  input  ADDR_W  data address of memory-stage instruction
snoop_inv  input  1  coherence invalidate seen this cycle
snoop_addr  input  ADDR_W  address of the invalidate
dREN  output  1  data read request
dWEN  output  1  data write request
sc_valid  output  1  one-cycle pulse: SC outcome available
sc_result  output  1  SC outcome (1 success, 0 fail); meaningful only with sc_valid
link_valid  output  1  link register valid (debug/visibility)
req_timeout  output  1  sticky watchdog flag

Behaviour:
- Reset (async, any state): dREN=dWEN=0, sc_valid=sc_result=0, link_valid=0, link_addr=0, watchdog count=0, req_timeout=0, state=IDLE.
- Addresses match when daddr[ADDR_W-1:LINK_LSB] equals the stored address in the same bits.
- State IDLE, with ihit=1 and cu_dren|cu_dwen:
  - Capture daddr, cu_ll and cu_sc.
  - If cu_dwen=1, the access is treated as a store and cu_dren is ignored.
  - Plain load or LL: next cycle dREN=1; go to PEND.
  - Plain store: next cycle dWEN=1; go to PEND.
  - SC with link_valid=1 and address match: next cycle dWEN=1; go to PEND.
  - SC otherwise: no memory request. Next cycle sc_valid=1, sc_result=0; go to SC_FAIL.
- IDLE with dhit=1 and no request: ignored.
- State PEND:
  - dREN/dWEN held stable, unaffected by ihit or cu_* changes.
  - On dhit: dREN=dWEN=0 next cycle; go to IDLE.
  - Completing LL: link_valid=1, link_addr=captured addr.
  - Completing SC: sc_valid=1, sc_result=1 next cycle; link_valid=0.
  - Completing plain store to an address matching link_addr: link_valid=0.
- State SC_FAIL: sc_valid=0 next cycle; go to IDLE. Exactly 1 cycle.
- Outputs are registered: dREN/dWEN rise exactly 1 cycle after the ihit edge and fall 1 cycle after the dhit edge.
- Snoop:
  - snoop_inv=1 with snoop_addr matching link_addr clears link_valid next cycle, in any state.
  - Same cycle as an LL dhit to the matching address: the link ends invalid (snoop wins).
  - Snoop while an SC is in PEND does not change the SC outcome (the decision is made at issue).
- Watchdog:
  - Count is cleared on entry to PEND and increments each PEND cycle, saturating at TIMEOUT.
  - When count reaches TIMEOUT while still in PEND, req_timeout=1 next cycle and stays 1 until RST.
  - The watchdog has no effect on the request; dREN/dWEN remain held.
- Width: the counter is $clog2(TIMEOUT+1) bits and never wraps.

Test Plan:
- Load: cu_dren=1 with ihit pulse; dhit 3 cycles later -> dREN=1 for exactly 3 cycles, then 0; dWEN=0 throughout.
- LL then SC: LL to 0x100, dhit; SC to 0x104 -> sc_valid pulse with sc_result=0 and no dWEN. SC to 0x100 -> dWEN=1; after dhit, sc_valid=1, sc_result=1, link_valid=0.
- Snoop kill: LL to 0x200 completes; snoop_inv with snoop_addr=0x203 (LINK_LSB=2) -> link_valid=0; next SC to 0x200 fails with no dWEN.
- Races: snoop_inv to 0x300 in the same cycle as the LL dhit to 0x300 -> link_valid=0. ihit and cu_dwen toggling during PEND -> dWEN unchanged.
- Watchdog (TIMEOUT=4): store with dhit withheld 10 cycles -> req_timeout=1 from the 5th pending cycle onward; dWEN still 1; flag persists after dhit.
- Reset mid-PEND: RST asserted while dWEN=1 and link valid -> all outputs 0 immediately (async); after release, first ihit+cu_dren produces a normal load.
